// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Registered RISC-V immediate generator. Each accepted instruction word is
//   decoded according to imm_sel_i into a sign- or zero-extended XLEN
//   immediate. The result is held in an output register with a one-entry skid
//   buffer behind it, so the consumer can stall without losing results.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   input transaction presented
//   in_ready_o   block can accept an input (registered)
//   instr_i      raw 32-bit instruction word
//   imm_sel_i    000 I, 001 S, 010 B, 011 U, 100 J, 101 Z, 110/111 illegal
//   tag_i        sideband tag travelling with the instruction
//   out_valid_o  registered result available
//   out_ready_i  consumer takes the result this cycle
//   imm_o        extended immediate
//   tag_o        tag paired with imm_o
//   illegal_o    result came from an illegal format select
//   dbg_state_o  storage state: 0 EMPTY, 1 ONE, 2 FULL
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its payload while valid is high and ready is
// low; out_* are held stable while out_valid_o=1 and out_ready_i=0. in_ready_o
// comes from a flop, so there is no combinational path from out_ready_i.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [2:0]       imm_sel_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;

  logic   in_fire;
  logic   out_fire;
  logic [31:0] imm32;
  entry_t new_entry;

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr_i[6:0];

  // ---------------------------------------------------------------------------
  // Immediate extraction. Every signed format carries instr[31] in bit 31 of
  // imm32, so a single sign extension to XLEN covers them all; Z has a zero
  // bit 31 and therefore extends with zeros.
  // ---------------------------------------------------------------------------
  always_comb begin
    imm32             = '0;
    new_entry.illegal = 1'b0;
    case (imm_sel_i)
      3'b000: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      3'b001: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      3'b010: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                       instr_i[30:25], instr_i[11:8], 1'b0};
      3'b011: imm32 = {instr_i[31:12], 12'b0};
      3'b100: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                       instr_i[20], instr_i[30:21], 1'b0};
      3'b101: imm32 = {27'b0, instr_i[19:15]};
      default: begin
        imm32             = '0;
        new_entry.illegal = 1'b1;
      end
    endcase
    new_entry.imm = XLEN'($signed(imm32));
    new_entry.tag = tag_i;
  end

  assign in_fire  = in_valid_i && in_ready_q;
  assign out_fire = out_valid_o && out_ready_i;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and storage update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({in_fire, out_fire})
          2'b10: begin
            skid_d  = new_entry;
            state_d = ST_FULL;
          end
          2'b01: state_d = ST_EMPTY;
          2'b11: main_d = new_entry;
          default: state_d = ST_ONE;
        endcase
      end
      ST_FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Ready for next cycle is decided from the state we are moving into,
    // which keeps in_ready_o a pure flop output.
    in_ready_d = (state_d != ST_FULL);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_o = (state_q != ST_EMPTY);
    in_ready_o  = in_ready_q;
    imm_o       = main_q.imm;
    tag_o       = main_q.tag;
    illegal_o   = main_q.illegal;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  localparam int TAG_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [31:0]      instr;
  logic [2:0]       sel;
  logic [TAG_W-1:0] tag_in;
  logic             out_ready;

  logic             in_ready;
  logic             out_valid;
  logic [31:0]      imm;
  logic [TAG_W-1:0] tag_out;
  logic             illegal;
  logic [1:0]       dbg_state;

  logic             in_ready64;
  logic             out_valid64;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] tag_out64;
  logic             illegal64;
  logic [1:0]       dbg_state64;

  int pass_cnt;
  int total_cnt;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .imm_sel_i(sel), .tag_i(tag_in), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .imm_o(imm), .tag_o(tag_out), .illegal_o(illegal),
    .dbg_state_o(dbg_state)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready64),
    .instr_i(instr), .imm_sel_i(sel), .tag_i(tag_in), .out_valid_o(out_valid64),
    .out_ready_i(out_ready), .imm_o(imm64), .tag_o(tag_out64), .illegal_o(illegal64),
    .dbg_state_o(dbg_state64)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks (called right after a negedge)
  task automatic drive_in(input logic v, input logic [2:0] s, input logic [31:0] w,
                          input logic [TAG_W-1:0] t);
    in_valid = v;
    sel      = s;
    instr    = w;
    tag_in   = t;
  endtask

  task automatic idle_in();
    drive_in(1'b0, 3'b000, 32'h0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({out_valid, in_ready, illegal, tag_out, imm} !== {1'b0, 1'b0, 1'b0, 8'h00, 32'h0}) begin
      $display("FAIL reset_values: got v=%0b rdy=%0b ill=%0b tag=%h imm=%h, want all zero",
               out_valid, in_ready, illegal, tag_out, imm);
    end else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10) begin
      $display("FAIL reset_release: got rdy=%0b v=%0b, want rdy=1 v=0", in_ready, out_valid);
    end else pass_cnt++;
  endtask

  task automatic test_single();
    drive_in(1'b1, 3'b000, 32'hFFF00093, 8'hA5);
    out_ready = 1'b1;
    @(negedge clk);
    idle_in();
    total_cnt++;
    if ({out_valid, illegal, tag_out, imm} !== {1'b1, 1'b0, 8'hA5, 32'hFFFFFFFF}) begin
      $display("FAIL single_i32: got v=%0b ill=%0b tag=%h imm=%h, want v=1 ill=0 tag=a5 imm=ffffffff",
               out_valid, illegal, tag_out, imm);
    end else pass_cnt++;
    total_cnt++;
    if ({out_valid64, imm64} !== {1'b1, 64'hFFFFFFFFFFFFFFFF}) begin
      $display("FAIL single_i64: got v=%0b imm=%h, want v=1 imm=ffffffffffffffff",
               out_valid64, imm64);
    end else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0) begin
      $display("FAIL single_drain: got v=%0b, want 0", out_valid);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  s_v [5];
    logic [31:0] w_v [5];
    logic [31:0] e32 [5];
    logic [63:0] e64 [5];
    s_v = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    w_v = '{32'hFE20AE23, 32'h00000863, 32'h123452B7, 32'hFF9FF06F, 32'h000F8073};
    e32 = '{32'hFFFFFFFC, 32'h00000010, 32'h12345000, 32'hFFFFFFF8, 32'h0000001F};
    e64 = '{64'hFFFFFFFFFFFFFFFC, 64'h10, 64'h12345000, 64'hFFFFFFFFFFFFFFF8, 64'h1F};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        total_cnt++;
        if ({out_valid, illegal, tag_out, imm} !== {1'b1, 1'b0, 8'(i), e32[i-1]}) begin
          $display("FAIL b2b_%0d: got v=%0b ill=%0b tag=%h imm=%h, want v=1 ill=0 tag=%h imm=%h",
                   i, out_valid, illegal, tag_out, imm, 8'(i), e32[i-1]);
        end else pass_cnt++;
        total_cnt++;
        if (imm64 !== e64[i-1]) begin
          $display("FAIL b2b64_%0d: got imm=%h, want %h", i, imm64, e64[i-1]);
        end else pass_cnt++;
      end
      if (i < 5) drive_in(1'b1, s_v[i], w_v[i], 8'(i + 1));
      else idle_in();
      @(negedge clk);
    end
    total_cnt++;
    if (out_valid !== 1'b0) begin
      $display("FAIL b2b_empty: got v=%0b, want 0", out_valid);
    end else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_in(1'b1, 3'd0, 32'h00100093, 8'd1);
    @(negedge clk);
    total_cnt++;
    if ({out_valid, in_ready, tag_out, imm} !== {1'b1, 1'b1, 8'd1, 32'd1}) begin
      $display("FAIL bp_first: got v=%0b rdy=%0b tag=%h imm=%h, want v=1 rdy=1 tag=01 imm=1",
               out_valid, in_ready, tag_out, imm);
    end else pass_cnt++;
    drive_in(1'b1, 3'd0, 32'h00200093, 8'd2);
    @(negedge clk);
    total_cnt++;
    if ({out_valid, in_ready, tag_out, imm} !== {1'b1, 1'b0, 8'd1, 32'd1}) begin
      $display("FAIL bp_full: got v=%0b rdy=%0b tag=%h imm=%h, want v=1 rdy=0 tag=01 imm=1",
               out_valid, in_ready, tag_out, imm);
    end else pass_cnt++;
    drive_in(1'b1, 3'd0, 32'h00300093, 8'd3);
    @(negedge clk);
    total_cnt++;
    if ({out_valid, in_ready, tag_out, imm} !== {1'b1, 1'b0, 8'd1, 32'd1}) begin
      $display("FAIL bp_hold: got v=%0b rdy=%0b tag=%h imm=%h, want v=1 rdy=0 tag=01 imm=1",
               out_valid, in_ready, tag_out, imm);
    end else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, in_ready, tag_out, imm} !== {1'b1, 1'b1, 8'd2, 32'd2}) begin
      $display("FAIL bp_drain2: got v=%0b rdy=%0b tag=%h imm=%h, want v=1 rdy=1 tag=02 imm=2",
               out_valid, in_ready, tag_out, imm);
    end else pass_cnt++;
    @(negedge clk);
    idle_in();
    total_cnt++;
    if ({out_valid, tag_out, imm} !== {1'b1, 8'd3, 32'd3}) begin
      $display("FAIL bp_drain3: got v=%0b tag=%h imm=%h, want v=1 tag=03 imm=3",
               out_valid, tag_out, imm);
    end else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0) begin
      $display("FAIL bp_no_dup: got v=%0b, want 0", out_valid);
    end else pass_cnt++;
  endtask

  task automatic test_throughput();
    logic [11:0] imm12 [16];
    logic [31:0] exp_v;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) imm12[i] = 12'(i * 12'h1A7);
    for (int i = 0; i < 17; i++) begin
      if (i > 0) begin
        exp_v = {{20{imm12[i-1][11]}}, imm12[i-1]};
        total_cnt++;
        if ({out_valid, in_ready, tag_out, imm} !== {1'b1, 1'b1, 8'(8'h10 + i - 1), exp_v}) begin
          $display("FAIL thru_%0d: got v=%0b rdy=%0b tag=%h imm=%h, want v=1 rdy=1 tag=%h imm=%h",
                   i - 1, out_valid, in_ready, tag_out, imm, 8'(8'h10 + i - 1), exp_v);
        end else pass_cnt++;
      end
      if (i < 16) drive_in(1'b1, 3'd0, {imm12[i], 20'h00093}, 8'(8'h10 + i));
      else idle_in();
      @(negedge clk);
    end
    total_cnt++;
    if (out_valid !== 1'b0) begin
      $display("FAIL thru_end: got v=%0b, want 0", out_valid);
    end else pass_cnt++;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive_in(1'b1, 3'b110, 32'hFFFFFFFF, 8'h77);
    @(negedge clk);
    total_cnt++;
    if ({out_valid, illegal, tag_out, imm} !== {1'b1, 1'b1, 8'h77, 32'h0}) begin
      $display("FAIL illegal_110: got v=%0b ill=%0b tag=%h imm=%h, want v=1 ill=1 tag=77 imm=0",
               out_valid, illegal, tag_out, imm);
    end else pass_cnt++;
    drive_in(1'b1, 3'b111, 32'hFFF00093, 8'h78);
    @(negedge clk);
    total_cnt++;
    if ({illegal, tag_out, imm} !== {1'b1, 8'h78, 32'h0}) begin
      $display("FAIL illegal_111: got ill=%0b tag=%h imm=%h, want ill=1 tag=78 imm=0",
               illegal, tag_out, imm);
    end else pass_cnt++;
    drive_in(1'b1, 3'b000, 32'hFFF00093, 8'h79);
    @(negedge clk);
    idle_in();
    total_cnt++;
    if ({out_valid, illegal, tag_out, imm} !== {1'b1, 1'b0, 8'h79, 32'hFFFFFFFF}) begin
      $display("FAIL illegal_clear: got v=%0b ill=%0b tag=%h imm=%h, want v=1 ill=0 tag=79 imm=ffffffff",
               out_valid, illegal, tag_out, imm);
    end else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive_in(1'b1, 3'd0, 32'h00500093, 8'h51);
    @(negedge clk);
    drive_in(1'b1, 3'd0, 32'h00600093, 8'h52);
    @(negedge clk);
    idle_in();
    total_cnt++;
    if ({out_valid, in_ready, dbg_state} !== {1'b1, 1'b0, 2'd2}) begin
      $display("FAIL areset_full: got v=%0b rdy=%0b st=%0d, want v=1 rdy=0 st=2",
               out_valid, in_ready, dbg_state);
    end else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, in_ready, illegal, tag_out, imm} !== {1'b0, 1'b0, 1'b0, 8'h00, 32'h0}) begin
      $display("FAIL areset_immediate: got v=%0b rdy=%0b ill=%0b tag=%h imm=%h, want all zero",
               out_valid, in_ready, illegal, tag_out, imm);
    end else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10) begin
      $display("FAIL areset_release: got rdy=%0b v=%0b, want rdy=1 v=0", in_ready, out_valid);
    end else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0) begin
      $display("FAIL areset_no_stale: got v=%0b, want 0", out_valid);
    end else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_throughput();
    test_illegal();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
